// File: rtl/store_narrow_unit.sv
// Narrows a 32-bit register value to byte/half/word and stores it into word-organised memory.
// Sub-word stores read the target word, merge the addressed lane(s), then write the whole word back.
module store_narrow_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    localparam int unsigned WORD_AW = ADDR_W - 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned HALF_W  = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        MERGE = 3'd3,
        ERR   = 3'd4
    } state_e;

    state_e              state_q;
    logic [WORD_AW-1:0]  mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_rd_en_q;
    logic                mem_wr_en_q;
    logic                done_q;
    logic                err_q;
    logic [1:0]          lane_q;
    logic [HALF_W-1:0]   data_q;
    logic [1:0]          size_q;

    logic                accept;
    logic                req_bad;

    // Replace only the addressed lane(s); every other byte comes from the old word.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [HALF_W-1:0] val,
        input logic [1:0]        lane,
        input logic              is_half
    );
        logic [DATA_W-1:0] w;
        w = old_word;
        if (is_half) begin
            if (lane[1]) w[31:16] = val;
            else         w[15:0]  = val;
        end else begin
            case (lane)
                2'd0:    w[7:0]   = val[7:0];
                2'd1:    w[15:8]  = val[7:0];
                2'd2:    w[23:16] = val[7:0];
                default: w[31:24] = val[7:0];
            endcase
        end
        return w;
    endfunction

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && (state_q == IDLE);
    assign req_bad   = (req_size == SZ_ILL)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lane_q      <= '0;
            data_q      <= '0;
            size_q      <= SZ_BYTE;
        end else begin
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mem_addr_q <= req_addr[ADDR_W-1:2];
                        lane_q     <= req_addr[1:0];
                        data_q     <= req_data[HALF_W-1:0];
                        size_q     <= req_size;
                        if (req_bad) begin
                            state_q <= ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state_q     <= WR;
                            mem_wr_en_q <= 1'b1;
                            mem_wdata_q <= req_data;
                            done_q      <= 1'b1;
                        end else begin
                            state_q     <= RD;
                            mem_rd_en_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state_q <= MERGE;
                end
                MERGE: begin
                    state_q     <= WR;
                    mem_wdata_q <= merge_word(mem_rdata, data_q, lane_q, size_q == SZ_HALF);
                    mem_wr_en_q <= 1'b1;
                    done_q      <= 1'b1;
                end
                WR:      state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: table of directed stores against a small synchronous memory,
// plus hand-written back-to-back and reset-during-merge sequences.
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    int total;
    int passed;

    logic [31:0] mem [0:15];
    logic        pre_en;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [31:0] init;
        logic [31:0] exp_mem;
        int          lat;
        int          exp_err;
        int          exp_rd;
        int          exp_wr;
        logic [29:0] exp_maddr;
    } vec_t;

    vec_t vecs [11];

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous word memory: read data valid the cycle after mem_rd_en.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
        if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    task automatic apply(input int id, input vec_t v);
        int done_cyc, done_cnt, err_cnt, rd_cnt, wr_cnt, ready_cyc, overlap;
        logic [29:0] maddr;
        logic [3:0]  idx;
        idx = v.addr[5:2];
        preload(idx, v.init);
        done_cyc = 0; done_cnt = 0; err_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        ready_cyc = 0; overlap = 0; maddr = '1;
        chk($sformatf("v%0d ready_before", id), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_data  = v.data;
        req_size  = v.size;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_addr  = 32'hFFFF_FFFF;
                req_data  = 32'h5A5A_5A5A;
                req_size  = 2'b10;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = k;
                    maddr    = mem_addr;
                end
            end
            if (err) err_cnt++;
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en && mem_wr_en) overlap++;
            if (req_ready && ready_cyc == 0) ready_cyc = k;
        end
        chk($sformatf("v%0d done_cycle", id), 32'(done_cyc), 32'(v.lat));
        chk($sformatf("v%0d done_count", id), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d err_count", id), 32'(err_cnt), 32'(v.exp_err));
        chk($sformatf("v%0d rd_count", id), 32'(rd_cnt), 32'(v.exp_rd));
        chk($sformatf("v%0d wr_count", id), 32'(wr_cnt), 32'(v.exp_wr));
        chk($sformatf("v%0d rd_wr_overlap", id), 32'(overlap), 32'd0);
        chk($sformatf("v%0d ready_cycle", id), 32'(ready_cyc), 32'(v.lat + 1));
        chk($sformatf("v%0d mem_addr", id), 32'(maddr), 32'(v.exp_maddr));
        chk($sformatf("v%0d mem_word", id), mem[idx], v.exp_mem);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cnt, rd_cnt, first_done, second_done, low_cnt, ready4;
        total = 0; passed = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;

        //                 addr          data          sz     init          exp_mem       lat er rd wr maddr
        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 32'h0000_0000, 32'hDEAD_BEEF, 1, 0, 0, 1, 30'h4};
        vecs[1]  = '{32'h0000_0012, 32'hFFFF_FFAB, 2'b00, 32'h1122_3344, 32'h11AB_3344, 3, 0, 1, 1, 30'h4};
        vecs[2]  = '{32'h0000_000E, 32'h0000_CAFE, 2'b01, 32'h5566_7788, 32'hCAFE_7788, 3, 0, 1, 1, 30'h3};
        vecs[3]  = '{32'h0000_0001, 32'h1234_5678, 2'b01, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 1, 0, 0, 30'h0};
        vecs[4]  = '{32'h0000_0002, 32'h1234_5678, 2'b10, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1, 1, 0, 0, 30'h0};
        vecs[5]  = '{32'h0000_0020, 32'h1234_5678, 2'b11, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1, 1, 0, 0, 30'h8};
        vecs[6]  = '{32'h0000_0014, 32'h1234_5678, 2'b00, 32'hAAAA_AAAA, 32'hAAAA_AA78, 3, 0, 1, 1, 30'h5};
        vecs[7]  = '{32'h0000_0017, 32'h0000_00C3, 2'b00, 32'h0102_0304, 32'hC302_0304, 3, 0, 1, 1, 30'h5};
        vecs[8]  = '{32'h0000_0019, 32'h0000_009A, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_9AFF, 3, 0, 1, 1, 30'h6};
        vecs[9]  = '{32'h0000_001C, 32'hBEEF_1234, 2'b01, 32'h8765_4321, 32'h8765_1234, 3, 0, 1, 1, 30'h7};
        vecs[10] = '{32'h0000_003C, 32'h0000_0000, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0, 1, 30'hF};

        #12;
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset outputs", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) apply(i, vecs[i]);

        // Back-to-back: valid held through a byte store, then a word store follows.
        preload(4'd9, 32'h1111_1111);
        req_valid = 1'b1; req_addr = 32'h24; req_data = 32'hABCD_EF55; req_size = 2'b00;
        wr_cnt = 0; rd_cnt = 0; first_done = 0; second_done = 0; low_cnt = 0; ready4 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_addr = 32'h28; req_data = 32'h1357_2468; req_size = 2'b10;
            end
            if (k <= 3 && !req_ready) low_cnt++;
            if (k == 4) ready4 = int'(req_ready);
            if (mem_wr_en) wr_cnt++;
            if (mem_rd_en) rd_cnt++;
            if (done) begin
                if (first_done == 0) first_done = k;
                else if (second_done == 0) second_done = k;
            end
            if (k == 5) req_valid = 1'b0;
        end
        chk("b2b ready_low_cycles", 32'(low_cnt), 32'd3);
        chk("b2b ready_at_t4", 32'(ready4), 32'd1);
        chk("b2b first_done", 32'(first_done), 32'd3);
        chk("b2b second_done", 32'(second_done), 32'd5);
        chk("b2b wr_count", 32'(wr_cnt), 32'd2);
        chk("b2b rd_count", 32'(rd_cnt), 32'd1);
        chk("b2b mem9", mem[9], 32'h1111_1155);
        chk("b2b mem10", mem[10], 32'h1357_2468);

        // Reset asserted while the byte store is in MERGE.
        preload(4'd12, 32'hCCCC_CCCC);
        req_valid = 1'b1; req_addr = 32'h30; req_data = 32'h0000_0077; req_size = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst mem_addr_before", 32'(mem_addr), 32'hC);
        rst_n = 1'b0;
        #1;
        chk("rst outputs", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst ready", 32'(req_ready), 32'd1);
        wr_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_wr_en) wr_cnt++;
            if (k == 1) rst_n = 1'b1;
        end
        chk("rst no_write", 32'(wr_cnt), 32'd0);
        chk("rst mem12", mem[12], 32'hCCCC_CCCC);
        apply(11, '{32'h0000_0030, 32'h0BAD_F00D, 2'b10, 32'hCCCC_CCCC, 32'h0BAD_F00D, 1, 0, 0, 1, 30'hC});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
